// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - six-stage pipelined floating-point add/subtract on unpacked operands
// Global-stall pipeline: every stage advances together whenever the output slot can move.
module fp_add_pipe #(
  parameter int EXP_W     = 7,
  parameter int FRAC_W    = 14,
  parameter bit ROUND_RNE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sub,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [EXP_W-1:0]  exp_a,
  input  logic [EXP_W-1:0]  exp_b,
  input  logic [FRAC_W-1:0] frac_a,
  input  logic [FRAC_W-1:0] frac_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_c,
  output logic [EXP_W-1:0]  exp_c,
  output logic [FRAC_W-1:0] frac_c,
  output logic              ovf,
  output logic              unf
);

  localparam int XW  = FRAC_W + 2;
  localparam int SW  = FRAC_W + 4;
  localparam int NW  = FRAC_W + 3;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(NW + 1);

  localparam logic [EXP_W:0]         D_MAX   = (EXP_W + 1)'(XW);
  localparam logic signed [EW-1:0]   E_MAX   = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0]   E_MIN   = EW'(-(2 ** (EXP_W - 1)));
  localparam logic [EXP_W-1:0]       EXP_SAT = {1'b0, {(EXP_W - 1){1'b1}}};

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic v1, v2, v3, v4, v5;

  // S1: effective sign, magnitude compare and swap
  logic              sign_bx, zero_a, zero_b, a_ge_b;
  logic [EXP_W+FRAC_W-1:0] key_a, key_b;

  assign sign_bx = sign_b ^ sub;
  assign zero_a  = (frac_a == '0);
  assign zero_b  = (frac_b == '0);
  // Flipping the exponent sign bit makes the signed exponent order as unsigned.
  assign key_a   = {~exp_a[EXP_W-1], exp_a[EXP_W-2:0], frac_a};
  assign key_b   = {~exp_b[EXP_W-1], exp_b[EXP_W-2:0], frac_b};
  assign a_ge_b  = zero_b | (~zero_a & (key_a >= key_b));

  logic              s1_sign_l, s1_eff_sub, s1_zero_sign;
  logic [EXP_W-1:0]  s1_exp_l, s1_exp_s;
  logic [FRAC_W-1:0] s1_frac_l, s1_frac_s;

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_l    <= a_ge_b ? sign_a : sign_bx;
      s1_eff_sub   <= sign_a ^ sign_bx;
      s1_zero_sign <= zero_a & zero_b & sign_a & sign_bx;
      s1_exp_l     <= a_ge_b ? exp_a  : exp_b;
      s1_exp_s     <= a_ge_b ? exp_b  : exp_a;
      s1_frac_l    <= a_ge_b ? frac_a : frac_b;
      s1_frac_s    <= a_ge_b ? frac_b : frac_a;
    end
  end

  // S2: align the smaller operand with guard, round and sticky
  logic [EXP_W:0]    d;
  logic [2*XW-1:0]   al_wide;
  logic [XW-1:0]     al_frac;
  logic              al_sticky;

  assign d = {s1_exp_l[EXP_W-1], s1_exp_l} - {s1_exp_s[EXP_W-1], s1_exp_s};

  always_comb begin
    al_wide = {s1_frac_s, 2'b00, {XW{1'b0}}} >> d;
    if (d >= D_MAX) begin
      al_frac   = '0;
      al_sticky = |s1_frac_s;
    end else begin
      al_frac   = al_wide[2*XW-1:XW];
      al_sticky = |al_wide[XW-1:0];
    end
  end

  logic              s2_sign_l, s2_eff_sub, s2_zero_sign, s2_al_sticky;
  logic [EXP_W-1:0]  s2_exp_l;
  logic [FRAC_W-1:0] s2_frac_l;
  logic [XW-1:0]     s2_al_frac;

  always_ff @(posedge clk) begin
    if (adv) begin
      s2_sign_l    <= s1_sign_l;
      s2_eff_sub   <= s1_eff_sub;
      s2_zero_sign <= s1_zero_sign;
      s2_exp_l     <= s1_exp_l;
      s2_frac_l    <= s1_frac_l;
      s2_al_frac   <= al_frac;
      s2_al_sticky <= al_sticky;
    end
  end

  // S3: magnitude add or subtract; L >= S so the difference is never negative
  logic [SW-1:0] op_l, op_s, sum;

  assign op_l = {1'b0, s2_frac_l, 3'b000};
  assign op_s = {1'b0, s2_al_frac, s2_al_sticky};
  assign sum  = s2_eff_sub ? (op_l - op_s) : (op_l + op_s);

  logic              s3_sign, s3_zero_sign;
  logic [EXP_W-1:0]  s3_exp;
  logic [SW-1:0]     s3_sum;

  always_ff @(posedge clk) begin
    if (adv) begin
      s3_sign      <= s2_sign_l;
      s3_zero_sign <= s2_zero_sign;
      s3_exp       <= s2_exp_l;
      s3_sum       <= sum;
    end
  end

  // S4: leading-zero count below the carry bit (NW when the field is empty)
  logic [LZW-1:0] lzc;

  always_comb begin
    lzc = LZW'(NW);
    for (int i = 0; i < NW; i++) begin
      if (s3_sum[i]) lzc = LZW'(NW - 1 - i);
    end
  end

  logic              s4_sign, s4_zero_sign;
  logic [EXP_W-1:0]  s4_exp;
  logic [SW-1:0]     s4_sum;
  logic [LZW-1:0]    s4_lzc;

  always_ff @(posedge clk) begin
    if (adv) begin
      s4_sign      <= s3_sign;
      s4_zero_sign <= s3_zero_sign;
      s4_exp       <= s3_exp;
      s4_sum       <= s3_sum;
      s4_lzc       <= lzc;
    end
  end

  // S5: normalise into {1.frac, G, R, sticky} with a widened exponent
  logic signed [EW-1:0] exp_ext, s5_e_n;
  logic [NW-1:0]        s5_n_n;

  assign exp_ext = {{2{s4_exp[EXP_W-1]}}, s4_exp};

  always_comb begin
    if (s4_sum[SW-1]) begin
      s5_n_n = {s4_sum[SW-1:2], s4_sum[1] | s4_sum[0]};
      s5_e_n = exp_ext + EW'(1);
    end else begin
      s5_n_n = s4_sum[NW-1:0] << s4_lzc;
      s5_e_n = exp_ext - EW'(s4_lzc);
    end
  end

  logic                 s5_sign, s5_zero_sign, s5_zero;
  logic [NW-1:0]        s5_n;
  logic signed [EW-1:0] s5_e;

  always_ff @(posedge clk) begin
    if (adv) begin
      s5_sign      <= s4_sign;
      s5_zero_sign <= s4_zero_sign;
      s5_zero      <= (s4_sum == '0);
      s5_n         <= s5_n_n;
      s5_e         <= s5_e_n;
    end
  end

  // S6: round, then saturate or flush against the exponent range
  logic                 inc;
  logic [FRAC_W:0]      rnd;
  logic [FRAC_W-1:0]    frac_r;
  logic signed [EW-1:0] e_r;
  logic                 r_sign, r_ovf, r_unf;
  logic [EXP_W-1:0]     r_exp;
  logic [FRAC_W-1:0]    r_frac;

  assign inc = ROUND_RNE & s5_n[2] & (s5_n[1] | s5_n[0] | s5_n[3]);
  assign rnd = {1'b0, s5_n[NW-1:3]} + (FRAC_W + 1)'(inc);

  always_comb begin
    if (rnd[FRAC_W]) begin
      frac_r = {1'b1, {(FRAC_W - 1){1'b0}}};
      e_r    = s5_e + EW'(1);
    end else begin
      frac_r = rnd[FRAC_W-1:0];
      e_r    = s5_e;
    end
    r_sign = 1'b0;
    r_exp  = '0;
    r_frac = '0;
    r_ovf  = 1'b0;
    r_unf  = 1'b0;
    if (s5_zero) begin
      r_sign = s5_zero_sign;
    end else if (e_r > E_MAX) begin
      r_sign = s5_sign;
      r_exp  = EXP_SAT;
      r_frac = '1;
      r_ovf  = 1'b1;
    end else if (e_r < E_MIN) begin
      r_unf  = 1'b1;
    end else begin
      r_sign = s5_sign;
      r_exp  = e_r[EXP_W-1:0];
      r_frac = frac_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      v5        <= 1'b0;
      out_valid <= 1'b0;
      sign_c    <= 1'b0;
      exp_c     <= '0;
      frac_c    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      v5        <= v4;
      out_valid <= v5;
      sign_c    <= r_sign;
      exp_c     <= r_exp;
      frac_c    <= r_frac;
      ovf       <= r_ovf;
      unf       <= r_unf;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb/tb_fp_add_pipe.sv - directed vector bench for fp_add_pipe
// A truncating twin instance shares the inputs so both rounding modes are checked per vector.
module tb_fp_add_pipe;

  localparam int EXP_W  = 7;
  localparam int FRAC_W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic sub = 1'b0, sign_a = 1'b0, sign_b = 1'b0;
  logic [EXP_W-1:0]  exp_a = '0, exp_b = '0;
  logic [FRAC_W-1:0] frac_a = '0, frac_b = '0;

  logic in_ready, out_valid, sign_c, ovf, unf;
  logic [EXP_W-1:0]  exp_c;
  logic [FRAC_W-1:0] frac_c;
  logic t_in_ready, t_out_valid, t_sign_c, t_ovf, t_unf;
  logic [EXP_W-1:0]  t_exp_c;
  logic [FRAC_W-1:0] t_frac_c;

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .ROUND_RNE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .frac_a(frac_a), .frac_b(frac_b), .out_valid(out_valid), .out_ready(out_ready),
    .sign_c(sign_c), .exp_c(exp_c), .frac_c(frac_c), .ovf(ovf), .unf(unf)
  );

  fp_add_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .ROUND_RNE(1'b0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready), .sub(sub),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .frac_a(frac_a), .frac_b(frac_b), .out_valid(t_out_valid), .out_ready(out_ready),
    .sign_c(t_sign_c), .exp_c(t_exp_c), .frac_c(t_frac_c), .ovf(t_ovf), .unf(t_unf)
  );

  typedef struct {
    logic              sub;
    logic              sa;
    logic [EXP_W-1:0]  ea;
    logic [FRAC_W-1:0] fa;
    logic              sb;
    logic [EXP_W-1:0]  eb;
    logic [FRAC_W-1:0] fb;
    logic              xs;
    logic [EXP_W-1:0]  xe;
    logic [FRAC_W-1:0] xf;
    logic              xo;
    logic              xu;
    logic [EXP_W-1:0]  te;
    logic [FRAC_W-1:0] tf;
  } vec_t;

  vec_t vt[16];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(input int su, input int sa, input int ea, input int fa,
                              input int sb, input int eb, input int fb,
                              input int xs, input int xe, input int xf,
                              input int xo, input int xu, input int te, input int tf);
    vec_t v;
    v.sub = su[0]; v.sa = sa[0]; v.ea = ea[EXP_W-1:0]; v.fa = fa[FRAC_W-1:0];
    v.sb = sb[0];  v.eb = eb[EXP_W-1:0]; v.fb = fb[FRAC_W-1:0];
    v.xs = xs[0];  v.xe = xe[EXP_W-1:0]; v.xf = xf[FRAC_W-1:0];
    v.xo = xo[0];  v.xu = xu[0];
    v.te = te[EXP_W-1:0]; v.tf = tf[FRAC_W-1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    sub = v.sub; sign_a = v.sa; exp_a = v.ea; frac_a = v.fa;
    sign_b = v.sb; exp_b = v.eb; frac_b = v.fb;
  endtask

  task automatic check_out(input int i, input string tag);
    chk($sformatf("%s%0d.sign", tag, i), 32'(sign_c), 32'(vt[i].xs));
    chk($sformatf("%s%0d.exp", tag, i),  32'(exp_c),  32'(vt[i].xe));
    chk($sformatf("%s%0d.frac", tag, i), 32'(frac_c), 32'(vt[i].xf));
    chk($sformatf("%s%0d.ovf", tag, i),  32'(ovf),    32'(vt[i].xo));
    chk($sformatf("%s%0d.unf", tag, i),  32'(unf),    32'(vt[i].xu));
  endtask

  task automatic run_vec(input int i);
    int lat;
    @(negedge clk);
    drive(vt[i]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d.latency", i), 32'(lat), 32'd6);
    check_out(i, "v");
    chk($sformatf("t%0d.valid", i), 32'(t_out_valid), 32'd1);
    chk($sformatf("t%0d.exp", i),   32'(t_exp_c),     32'(vt[i].te));
    chk($sformatf("t%0d.frac", i),  32'(t_frac_c),    32'(vt[i].tf));
    @(negedge clk);
    chk($sformatf("v%0d.no_dup", i), 32'(out_valid), 32'd0);
  endtask

  initial begin
    int idx, got, stall_left, cyc, extra;
    bit stalled_once, prev_stall;
    logic ps, po, pu;
    logic [EXP_W-1:0]  pe;
    logic [FRAC_W-1:0] pf;

    //          su sa  ea   fa      sb  eb   fb       xs  xe   xf      xo xu  te   tf
    vt[0]  = mk(0, 0,   0, 'h2000, 0,   0, 'h2000,  0,   1, 'h2000, 0, 0,   1, 'h2000);
    vt[1]  = mk(1, 0,   0, 'h2000, 0,   0, 'h2000,  0,   0, 0,      0, 0,   0, 0);
    vt[2]  = mk(0, 1,   0, 0,      1,   0, 0,       1,   0, 0,      0, 0,   0, 0);
    vt[3]  = mk(0, 0,   0, 'h2000, 0, -14, 'h2000,  0,   0, 'h2000, 0, 0,   0, 'h2000);
    vt[4]  = mk(0, 0,   0, 'h2000, 0, -14, 'h3000,  0,   0, 'h2001, 0, 0,   0, 'h2000);
    vt[5]  = mk(0, 0,   0, 'h2000, 0, -40, 'h2000,  0,   0, 'h2000, 0, 0,   0, 'h2000);
    vt[6]  = mk(0, 0,  63, 'h3000, 0,  63, 'h3000,  0,  63, 'h3FFF, 1, 0,  63, 'h3FFF);
    vt[7]  = mk(1, 0, -64, 'h3000, 0, -64, 'h2000,  0,   0, 0,      0, 1,   0, 0);
    vt[8]  = mk(1, 0,   0, 'h2000, 0,  -1, 'h3000,  0,  -2, 'h2000, 0, 0,  -2, 'h2000);
    vt[9]  = mk(0, 1,   0, 'h2000, 0,  -1, 'h2000,  1,  -1, 'h2000, 0, 0,  -1, 'h2000);
    vt[10] = mk(1, 0,  -1, 'h2000, 0,   0, 'h2000,  1,  -1, 'h2000, 0, 0,  -1, 'h2000);
    vt[11] = mk(0, 0,   0, 'h2000, 0,   0, 0,       0,   0, 'h2000, 0, 0,   0, 'h2000);
    vt[12] = mk(0, 0,   0, 0,      1,   0, 'h2000,  1,   0, 'h2000, 0, 0,   0, 'h2000);
    vt[13] = mk(0, 0,   0, 'h3000, 0,   0, 'h3000,  0,   1, 'h3000, 0, 0,   1, 'h3000);
    vt[14] = mk(0, 0,   0, 'h2000, 0,   0, 'h2003,  0,   1, 'h2002, 0, 0,   1, 'h2001);
    vt[15] = mk(0, 0,   0, 'h3FFF, 0, -14, 'h3000,  0,   1, 'h2000, 0, 0,   0, 'h3FFF);

    repeat (3) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sign_c",    32'(sign_c),    32'd0);
    chk("rst.exp_c",     32'(exp_c),     32'd0);
    chk("rst.frac_c",    32'(frac_c),    32'd0);
    chk("rst.ovf",       32'(ovf),       32'd0);
    chk("rst.unf",       32'(unf),       32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Back-to-back stream of vectors 0..9 with a 3-cycle consumer stall.
    idx = 0; got = 0; stall_left = 0; cyc = 0;
    stalled_once = 1'b0; prev_stall = 1'b0;
    ps = 1'b0; pe = '0; pf = '0; po = 1'b0; pu = 1'b0;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!stalled_once && got == 1 && out_valid) begin
        stall_left   = 3;
        stalled_once = 1'b1;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (idx < 10) begin
        drive(vt[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk("hold.valid", 32'(out_valid), 32'd1);
        chk("hold.sign",  32'(sign_c),    32'(ps));
        chk("hold.exp",   32'(exp_c),     32'(pe));
        chk("hold.frac",  32'(frac_c),    32'(pf));
        chk("hold.flags", 32'({ovf, unf}), 32'({po, pu}));
      end
      if (out_valid && !out_ready) chk("stall.in_ready", 32'(in_ready), 32'd0);
      prev_stall = out_valid && !out_ready;
      ps = sign_c; pe = exp_c; pf = frac_c; po = ovf; pu = unf;
      if (out_valid && out_ready) begin
        check_out(got, "s");
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    chk("stream.count",  32'(got), 32'd10);
    chk("stream.stalled", 32'(stalled_once), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream.extra", 32'(extra), 32'd0);

    // Reset with four operations in flight.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(vt[10 + k]);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.exp_c",     32'(exp_c),     32'd0);
    chk("midrst.frac_c",    32'(frac_c),    32'd0);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("midrst.stale", 32'(extra), 32'd0);
    run_vec(13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
